phasor_bank: RTL and testbench
==============================

# phasor_bank

Time-multiplexed bank of NV phase accumulators, the multi-voice successor to the single-voice phasor. On each sample tick it sweeps all voices, one per clock. Each voice has its own increment, phase offset, FM input, enable and optional hard sync to the previous voice. It emits a stream of (voice, wavetable address, interpolation fraction) words to the shared wavetable/interpolator pipeline.

## Interface
- NV, 8: number of voices (≥2); VW = max(1, $clog2(NV)).
- DW, 32: phase precision.
- AW, 12: wavetable address width; IW = DW-AW.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- SampleTick  in  1  single-cycle pulse starting a sweep.
- CfgWe  in  1  config write strobe.
- CfgVoice  in  VW  target voice.
- CfgSel  in  2  0=increment, 1=offset, 2=phase load, 3=control (bit0 enable, bit1 syncEn).
- CfgData  in  DW  write data.
- FmVoice  out  VW  voice currently being processed (valid while Busy).
- FmInput  in  DW  two's-complement FM term for FmVoice, sampled the same cycle.
- Busy  out  1  sweep in progress.
- OutValid  out  1  output word valid.
- OutVoice  out  VW  voice of output word.
- WavetableAddr  out  AW  phase_addr[DW-1:IW].
- Interp  out  IW  phase_addr[IW-1:0].
- OutWrap  out  1  voice's accumulator wrapped this update.
- SweepDone  out  1  pulses with the last voice's word.
- Overrun  out  1  sticky: tick arrived while busy.

## Operation
- Per voice: inc[v], off[v], phase[v] (DW bits); en[v], syncEn[v]. All reset to 0.
- FSM: IDLE, RUN; counter vcnt (VW bits).
  - IDLE + SampleTick → RUN, vcnt=0.
  - RUN: process voice vcnt each cycle. At vcnt=NV-1 → IDLE. Otherwise vcnt+1.
- Processing voice v:
  - freq = inc[v] + FmInput (mod 2^DW).
  - {carry, sum} = phase[v] + freq, computed in DW+1 bits.
  - wrap = carry & en[v].
  - Output phase_addr = phase[v] + off[v] (mod 2^DW), using the pre-update phase, as in the single-voice phasor.
  - Next phase:
    - en[v]=0 → hold.
    - syncEn[v]=1, v>0, and voice v-1 wrapped earlier in this sweep → 0.
    - Otherwise → sum.
  - syncEn on voice 0 is ignored.
  - prevWrap is a 1-bit register holding the wrap of the previous processed voice. It is cleared at sweep start.
- Disabled voices still emit an output word, with held phase and OutWrap=0.
- Config writes are accepted in any state and take effect at the edge.
  - If a write targets the voice being processed in the same cycle: processing uses the old inc/off/control values.
  - A phase load wins over that cycle's accumulator update.
- SampleTick while Busy, including the final RUN cycle, is dropped and sets Overrun. Overrun clears only on Reset.

## Timing
- Reset asserted: immediately IDLE, vcnt=0, all outputs 0, all voice registers 0.
  - Mid-sweep Reset aborts the sweep with no further OutValid.
- Tick sampled at edge k:
  - Busy is high after edge k through edge k+NV.
  - FmVoice=i during the cycle after edge k+i.
- Output word for voice i is registered at edge k+1+i.
  - OutValid is high for NV consecutive cycles.
  - SweepDone accompanies voice NV-1.
- Earliest accepted next tick: edge k+NV+1. Minimum tick period is NV+1 cycles.
- Output registers hold their last values when OutValid=0.

## Test plan
- Reset mid-sweep (after voice 3 output) → OutValid drops immediately. All outputs are 0. Next tick restarts at voice 0 with phase 0.
- NV=4, DW=32, AW=12, inc[1]=0x0010_0000, off=0, en=1, FM=0. Run 3 ticks → voice 1 outputs Addr=0,1,2 with Interp=0, OutValid for 4 cycles per sweep, SweepDone on voice 3.
- FM: inc[0]=0x1000_0000, FmInput=0xF000_0000 (−2^28) → phase stays 0 and no wrap. With off[0]=0x8000_0000 → Addr=0x800.
- Wrap: phase load 0xFFFF_FFF0, inc=0x20 → next sweep OutWrap=1 and phase becomes 0x10. With syncEn[2]=1, voice 2 phase=0 that sweep, while voice 3 (no sync) is unaffected.
- Tick held 2 cycles, then a tick on the final RUN cycle → exactly one sweep of NV words. Overrun=1, staying set until Reset.
- Phase-load write to voice 2 in the same cycle voice 2 is processed → stored phase equals CfgData. The output word that cycle uses the old phase.

Source files
------------

// File: rtl/phasor_bank_if.sv
// Bus bundle for phasor_bank: sweep trigger, voice configuration, FM feed and
// the (voice, address, fraction) output stream toward the wavetable pipeline.
interface phasor_bank_if #(
  parameter int NV = 8,
  parameter int DW = 32,
  parameter int AW = 12
);
  localparam int VW = (NV > 1) ? $clog2(NV) : 1;
  localparam int IW = DW - AW;

  logic          SampleTick;
  logic          CfgWe;
  logic [VW-1:0] CfgVoice;
  logic [1:0]    CfgSel;
  logic [DW-1:0] CfgData;
  logic [VW-1:0] FmVoice;
  logic [DW-1:0] FmInput;
  logic          Busy;
  logic          OutValid;
  logic [VW-1:0] OutVoice;
  logic [AW-1:0] WavetableAddr;
  logic [IW-1:0] Interp;
  logic          OutWrap;
  logic          SweepDone;
  logic          Overrun;

  modport master (
    output SampleTick, CfgWe, CfgVoice, CfgSel, CfgData, FmInput,
    input  FmVoice, Busy, OutValid, OutVoice, WavetableAddr, Interp,
           OutWrap, SweepDone, Overrun
  );

  modport slave (
    input  SampleTick, CfgWe, CfgVoice, CfgSel, CfgData, FmInput,
    output FmVoice, Busy, OutValid, OutVoice, WavetableAddr, Interp,
           OutWrap, SweepDone, Overrun
  );
endinterface

// File: rtl/phasor_bank.sv
// Time-multiplexed bank of NV phase accumulators, one voice per clock per sweep,
// with per-voice increment, offset, FM, enable and hard sync to the previous voice.
module phasor_bank #(
  parameter int NV = 8,
  parameter int DW = 32,
  parameter int AW = 12
) (
  input logic          Clk,
  input logic          Reset,
  phasor_bank_if.slave bus
);
  localparam int VW = (NV > 1) ? $clog2(NV) : 1;
  localparam int IW = DW - AW;
  localparam logic [VW-1:0] LAST_VOICE = VW'(NV - 1);
  localparam logic [VW-1:0] VOICE_ZERO = {VW{1'b0}};

  localparam logic [1:0] SEL_INC   = 2'd0;
  localparam logic [1:0] SEL_OFF   = 2'd1;
  localparam logic [1:0] SEL_PHASE = 2'd2;
  localparam logic [1:0] SEL_CTRL  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [VW-1:0] vcnt_r;
  logic [VW-1:0] vcnt_nx_s;

  logic [DW-1:0] inc_r   [NV];
  logic [DW-1:0] off_r   [NV];
  logic [DW-1:0] phase_r [NV];
  logic [NV-1:0] en_r;
  logic [NV-1:0] sync_en_r;

  logic          prev_wrap_r;
  logic          busy_r;
  logic          overrun_r;

  logic          out_valid_r;
  logic [VW-1:0] out_voice_r;
  logic [AW-1:0] addr_r;
  logic [IW-1:0] interp_r;
  logic          out_wrap_r;
  logic          sweep_done_r;

  logic          run_s;
  logic          start_s;
  logic          last_s;
  logic          cfg_hit_s;
  logic [DW-1:0] cur_inc_s;
  logic [DW-1:0] cur_off_s;
  logic [DW-1:0] cur_phase_s;
  logic          cur_en_s;
  logic          cur_sync_s;
  logic [DW-1:0] freq_s;
  logic [DW:0]   sum_s;
  logic          wrap_s;
  logic          sync_hit_s;
  logic [DW-1:0] addr_s;
  logic [DW-1:0] next_phase_s;

  assign run_s     = (state_r == ST_RUN);
  assign start_s   = (state_r == ST_IDLE) && bus.SampleTick;
  assign last_s    = (vcnt_r == LAST_VOICE);
  assign cfg_hit_s = bus.CfgWe && (bus.CfgVoice <= LAST_VOICE);

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      vcnt_r  <= VOICE_ZERO;
    end else begin
      state_r <= state_nx_s;
      vcnt_r  <= vcnt_nx_s;
    end
  end

  // FSM next-state: one voice per RUN cycle, back to IDLE after the last voice
  always_comb begin
    state_nx_s = state_r;
    vcnt_nx_s  = vcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.SampleTick) begin
          state_nx_s = ST_RUN;
          vcnt_nx_s  = VOICE_ZERO;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nx_s = ST_IDLE;
          vcnt_nx_s  = VOICE_ZERO;
        end else begin
          vcnt_nx_s  = vcnt_r + {{(VW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        vcnt_nx_s  = VOICE_ZERO;
      end
    endcase
  end

  // Datapath for the voice selected by vcnt; reads the pre-write register values
  always_comb begin
    cur_inc_s   = inc_r[vcnt_r];
    cur_off_s   = off_r[vcnt_r];
    cur_phase_s = phase_r[vcnt_r];
    cur_en_s    = en_r[vcnt_r];
    cur_sync_s  = sync_en_r[vcnt_r];
    freq_s      = cur_inc_s + bus.FmInput;
    sum_s       = {1'b0, cur_phase_s} + {1'b0, freq_s};
    wrap_s      = sum_s[DW] & cur_en_s;
    addr_s      = cur_phase_s + cur_off_s;
    // voice 0 has no predecessor, so its sync enable is ignored
    sync_hit_s  = cur_sync_s && prev_wrap_r && (vcnt_r != VOICE_ZERO);
    if (!cur_en_s) begin
      next_phase_s = cur_phase_s;
    end else if (sync_hit_s) begin
      next_phase_s = {DW{1'b0}};
    end else begin
      next_phase_s = sum_s[DW-1:0];
    end
  end

  // Per-voice registers: accumulator update, then config write (phase load wins)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int v = 0; v < NV; v++) begin
        inc_r[v]   <= {DW{1'b0}};
        off_r[v]   <= {DW{1'b0}};
        phase_r[v] <= {DW{1'b0}};
      end
      en_r      <= {NV{1'b0}};
      sync_en_r <= {NV{1'b0}};
    end else begin
      if (run_s) begin
        phase_r[vcnt_r] <= next_phase_s;
      end
      if (cfg_hit_s) begin
        case (bus.CfgSel)
          SEL_INC:   inc_r[bus.CfgVoice]   <= bus.CfgData;
          SEL_OFF:   off_r[bus.CfgVoice]   <= bus.CfgData;
          SEL_PHASE: phase_r[bus.CfgVoice] <= bus.CfgData;
          SEL_CTRL: begin
            en_r[bus.CfgVoice]      <= bus.CfgData[0];
            sync_en_r[bus.CfgVoice] <= bus.CfgData[1];
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Wrap of the previously processed voice, cleared when a sweep starts
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prev_wrap_r <= 1'b0;
    end else if (start_s) begin
      prev_wrap_r <= 1'b0;
    end else if (run_s) begin
      prev_wrap_r <= wrap_s;
    end else begin
      prev_wrap_r <= prev_wrap_r;
    end
  end

  // Busy mirrors the next FSM state; Overrun is sticky until Reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_RUN);
      if (bus.SampleTick && run_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // Output word registers; data fields hold while no word is emitted
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid_r  <= 1'b0;
      out_voice_r  <= VOICE_ZERO;
      addr_r       <= {AW{1'b0}};
      interp_r     <= {IW{1'b0}};
      out_wrap_r   <= 1'b0;
      sweep_done_r <= 1'b0;
    end else if (run_s) begin
      out_valid_r  <= 1'b1;
      out_voice_r  <= vcnt_r;
      addr_r       <= addr_s[DW-1:IW];
      interp_r     <= addr_s[IW-1:0];
      out_wrap_r   <= wrap_s;
      sweep_done_r <= last_s;
    end else begin
      out_valid_r  <= 1'b0;
      sweep_done_r <= 1'b0;
    end
  end

  assign bus.FmVoice       = vcnt_r;
  assign bus.Busy          = busy_r;
  assign bus.OutValid      = out_valid_r;
  assign bus.OutVoice      = out_voice_r;
  assign bus.WavetableAddr = addr_r;
  assign bus.Interp        = interp_r;
  assign bus.OutWrap       = out_wrap_r;
  assign bus.SweepDone     = sweep_done_r;
  assign bus.Overrun       = overrun_r;

endmodule

// File: tb/tb_phasor_bank.sv
// Directed self-checking bench for phasor_bank with NV=4, DW=32, AW=12.
module tb_phasor_bank;
  localparam int NV = 4;
  localparam int DW = 32;
  localparam int AW = 12;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  phasor_bank_if #(.NV(NV), .DW(DW), .AW(AW)) bus ();

  phasor_bank #(.NV(NV), .DW(DW), .AW(AW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [31:0] fm_tab   [4];
  logic [11:0] c_addr   [4];
  logic [19:0] c_interp [4];
  logic [1:0]  c_voice  [4];
  logic [1:0]  c_fmv    [4];
  logic [3:0]  c_valid;
  logic [3:0]  c_done;
  logic [3:0]  c_wrap;
  logic [3:0]  c_busy;
  logic        post_busy;
  logic        post_valid;
  int          nwords;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg(input int v, input int sel, input logic [31:0] d);
    bus.CfgWe    = 1'b1;
    bus.CfgVoice = v[1:0];
    bus.CfgSel   = sel[1:0];
    bus.CfgData  = d;
    step();
    bus.CfgWe    = 1'b0;
  endtask

  // One full sweep; optionally loads phase of voice ld_i while that voice is processed
  task automatic sweep(input int ld_i, input logic [31:0] ld_d);
    bus.SampleTick = 1'b1;
    step();
    bus.SampleTick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_busy[i]   = bus.Busy;
      c_fmv[i]    = bus.FmVoice;
      bus.FmInput = fm_tab[i];
      if (i == ld_i) begin
        bus.CfgWe    = 1'b1;
        bus.CfgVoice = ld_i[1:0];
        bus.CfgSel   = 2'd2;
        bus.CfgData  = ld_d;
      end
      step();
      bus.CfgWe     = 1'b0;
      bus.FmInput   = 32'h0;
      c_valid[i]    = bus.OutValid;
      c_done[i]     = bus.SweepDone;
      c_wrap[i]     = bus.OutWrap;
      c_voice[i]    = bus.OutVoice;
      c_addr[i]     = bus.WavetableAddr;
      c_interp[i]   = bus.Interp;
    end
    post_busy = bus.Busy;
    step();
    post_valid = bus.OutValid;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset = 1'b1;
    bus.SampleTick = 1'b0;
    bus.CfgWe      = 1'b0;
    bus.CfgVoice   = 2'd0;
    bus.CfgSel     = 2'd0;
    bus.CfgData    = 32'h0;
    bus.FmInput    = 32'h0;
    for (int i = 0; i < 4; i++) fm_tab[i] = 32'h0;
    step();
    step();
    chk("reset_outputs", {23'd0, bus.OutValid, bus.Busy, bus.Overrun, bus.SweepDone, bus.OutWrap,
        bus.OutVoice, bus.FmVoice, bus.WavetableAddr, bus.Interp}, 64'h0);
    Reset = 1'b0;
    step();

    // Basic sweep: all voices enabled, voice 1 steps one table entry per sweep
    for (int v = 0; v < 4; v++) cfg(v, 3, 32'h1);
    cfg(1, 0, 32'h0010_0000);
    sweep(-1, 32'h0);
    chk("s1_valid", {60'd0, c_valid}, 64'hF);
    chk("s1_done", {60'd0, c_done}, 64'h8);
    chk("s1_busy", {59'd0, post_busy, c_busy}, 64'hF);
    chk("s1_voice", {56'd0, c_voice[3], c_voice[2], c_voice[1], c_voice[0]}, 64'hE4);
    chk("s1_fmvoice", {56'd0, c_fmv[3], c_fmv[2], c_fmv[1], c_fmv[0]}, 64'hE4);
    chk("s1_post_valid", {63'd0, post_valid}, 64'h0);
    chk("s1_v1_addr", {52'd0, c_addr[1]}, 64'h000);
    sweep(-1, 32'h0);
    chk("s2_v1_addr", {32'd0, c_addr[1], c_interp[1]}, 64'h0010_0000);
    sweep(-1, 32'h0);
    chk("s3_v1_addr", {32'd0, c_addr[1], c_interp[1]}, 64'h0020_0000);
    chk("s3_done", {60'd0, c_done}, 64'h8);

    // FM cancels the increment of voice 0; offset shifts the output address
    cfg(0, 0, 32'h1000_0000);
    cfg(0, 1, 32'h8000_0000);
    fm_tab[0] = 32'hF000_0000;
    sweep(-1, 32'h0);
    chk("fm1_v0_addr", {32'd0, c_addr[0], c_interp[0]}, 64'h8000_0000);
    chk("fm1_v0_wrap", {63'd0, c_wrap[0]}, 64'h0);
    chk("fm1_v1_addr", {52'd0, c_addr[1]}, 64'h003);
    sweep(-1, 32'h0);
    chk("fm2_v0_addr", {32'd0, c_addr[0], c_interp[0]}, 64'h8000_0000);
    fm_tab[0] = 32'h0;
    sweep(-1, 32'h0);
    chk("fm3_v0_addr", {52'd0, c_addr[0]}, 64'h800);
    sweep(-1, 32'h0);
    chk("fm4_v0_addr", {52'd0, c_addr[0]}, 64'h900);

    // Wrap and hard sync: voice 1 wraps and resets synced voice 2; voice 3 has no sync
    cfg(1, 2, 32'hFFFF_FFF0);
    cfg(1, 0, 32'h0000_0020);
    cfg(2, 2, 32'hFFFF_FF00);
    cfg(2, 0, 32'h0000_0200);
    cfg(2, 3, 32'h3);
    cfg(3, 2, 32'h0800_0000);
    cfg(3, 0, 32'h0000_0100);
    sweep(-1, 32'h0);
    chk("wa_wrap", {60'd0, c_wrap}, 64'h6);
    chk("wa_v0_addr", {52'd0, c_addr[0]}, 64'hA00);
    chk("wa_v1_word", {32'd0, c_addr[1], c_interp[1]}, 64'hFFFF_FFF0);
    chk("wa_v2_word", {32'd0, c_addr[2], c_interp[2]}, 64'hFFFF_FF00);
    chk("wa_v3_word", {32'd0, c_addr[3], c_interp[3]}, 64'h0800_0000);
    sweep(-1, 32'h0);
    chk("wb_wrap", {60'd0, c_wrap}, 64'h0);
    chk("wb_v1_word", {32'd0, c_addr[1], c_interp[1]}, 64'h0000_0010);
    chk("wb_v2_synced", {32'd0, c_addr[2], c_interp[2]}, 64'h0000_0000);
    chk("wb_v3_free", {32'd0, c_addr[3], c_interp[3]}, 64'h0800_0100);

    // Overrun: tick held two cycles plus a tick on the final RUN cycle
    chk("ovr_before", {63'd0, bus.Overrun}, 64'h0);
    nwords = 0;
    for (int c = 0; c < 12; c++) begin
      bus.SampleTick = (c == 0) || (c == 1) || (c == 4);
      step();
      if (bus.OutValid) nwords++;
    end
    bus.SampleTick = 1'b0;
    chk("ovr_words", 64'(nwords), 64'd4);
    chk("ovr_set", {63'd0, bus.Overrun}, 64'h1);

    // Phase load to voice 2 in the cycle it is processed
    sweep(2, 32'hABCD_E000);
    chk("ld_voice", {62'd0, c_voice[2]}, 64'h2);
    chk("ld_old_phase", {32'd0, c_addr[2], c_interp[2]}, 64'h0000_0400);
    sweep(-1, 32'h0);
    chk("ld_new_phase", {32'd0, c_addr[2], c_interp[2]}, 64'hABCD_E000);
    chk("ovr_sticky", {63'd0, bus.Overrun}, 64'h1);

    // Reset in the middle of a sweep
    bus.SampleTick = 1'b1;
    step();
    bus.SampleTick = 1'b0;
    step();
    step();
    step();
    chk("mid_valid_pre", {63'd0, bus.OutValid}, 64'h1);
    Reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {23'd0, bus.OutValid, bus.Busy, bus.Overrun, bus.SweepDone, bus.OutWrap,
        bus.OutVoice, bus.FmVoice, bus.WavetableAddr, bus.Interp}, 64'h0);
    Reset = 1'b0;
    step();
    chk("mid_no_valid", {62'd0, bus.OutValid, bus.Busy}, 64'h0);

    // Restart from voice 0 with cleared state; voice 1 stays disabled
    cfg(0, 3, 32'h1);
    cfg(0, 0, 32'h0400_0000);
    cfg(1, 2, 32'hFFFF_FFF0);
    cfg(1, 0, 32'h0000_0020);
    sweep(-1, 32'h0);
    chk("rs_v0_word", {30'd0, c_voice[0], c_addr[0], c_interp[0]}, 64'h0);
    chk("rs_valid", {60'd0, c_valid}, 64'hF);
    chk("rs_v1_disabled", {31'd0, c_wrap[1], c_addr[1], c_interp[1]}, 64'hFFFF_FFF0);
    sweep(-1, 32'h0);
    chk("rs2_v0_addr", {52'd0, c_addr[0]}, 64'h040);
    chk("rs2_v1_held", {31'd0, c_wrap[1], c_addr[1], c_interp[1]}, 64'hFFFF_FFF0);
    chk("rs2_overrun", {63'd0, bus.Overrun}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
